// File: rtl/vscale_hasti_sram_slave.sv
// AHB-Lite (HASTI) responder around a word-organised single-port SRAM.
// Define VSCALE_HASTI_SLAVE_WAIT_EN to build the data-phase wait-state counter.
module vscale_hasti_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state, state_next;
    logic            accept;
    logic            addr_err;
    logic            wait_done;
    logic [AW-1:0]   cap_idx;
    logic            cap_write;
    logic [2:0]      cap_size;
    logic [1:0]      cap_off;
    logic [3:0]      byte_en;
    logic [31:0]     mem [DEPTH];

    // Address phases are only sampled while hready is high, so BUSY/IDLE during waits is ignored.
    assign accept = hready && hsel && htrans[1];

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        addr_err = 1'b0;
        if ({2'b00, haddr[31:2]} >= 32'(DEPTH)) addr_err = 1'b1;
        if (hsize > 3'd2)                       addr_err = 1'b1;
        if (hsize == 3'd1 && haddr[0])          addr_err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00) addr_err = 1'b1;
    end

`ifdef VSCALE_HASTI_SLAVE_WAIT_EN
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_STATES);

    logic [CW-1:0] wait_cnt;

    // Counts only while a data phase is stalled, so it is zero on every entry to DATA and never wraps.
    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_DATA && !wait_done) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign wait_done = (wait_cnt == WAIT_LAST);
`else
    assign wait_done = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_size  <= 3'd0;
            cap_off   <= 2'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_idx   <= haddr[AW+1:2];
                cap_write <= hwrite;
                cap_size  <= hsize;
                cap_off   <= haddr[1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        hready     = 1'b1;
        hresp      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) state_next = addr_err ? S_ERR1 : S_DATA;
            end
            S_DATA: begin
                hready = wait_done;
                if (wait_done) begin
                    if (accept) state_next = addr_err ? S_ERR1 : S_DATA;
                    else        state_next = S_IDLE;
                end
            end
            S_ERR1: begin
                hready     = 1'b0;
                hresp      = 1'b1;
                state_next = S_ERR2;
            end
            S_ERR2: begin
                hresp = 1'b1;
                if (accept) state_next = addr_err ? S_ERR1 : S_DATA;
                else        state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_en = 4'b0000;
        case (cap_size)
            3'd0:    byte_en[cap_off] = 1'b1;
            3'd1:    byte_en = cap_off[1] ? 4'b1100 : 4'b0011;
            3'd2:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // NOTE: the memory array has no reset; only control state is cleared, which is enough to drop an in-flight write.
    always_ff @(posedge hclk) begin
        if (state == S_DATA && wait_done && cap_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[cap_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hrdata = (state == S_DATA && !cap_write) ? mem[cap_idx] : 32'h0;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Directed self-checking bench for vscale_hasti_sram_slave (zero-wait default, two waits with VSCALE_HASTI_SLAVE_WAIT_EN).
module tb_vscale_hasti_sram_slave;

    localparam int DEPTH = 1024;
`ifdef VSCALE_HASTI_SLAVE_WAIT_EN
    localparam int WS = 2;
`else
    localparam int WS = 0;
`endif

    logic        hclk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int passed = 0;
    int total  = 0;

    vscale_hasti_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut (
        .hclk      (hclk),
        .reset     (reset),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hmastlock (hmastlock),
        .hprot     (hprot),
        .htrans    (htrans),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    // One isolated transfer; returns the data/response seen in the completing cycle.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic resp);
        int n;
        addr_phase(wr, a, sz);
        next_cycle();
        idle_bus();
        hwdata = wd;
        n = 0;
        @(negedge hclk);
        while (!hready && n < 20) begin
            n++;
            next_cycle();
            @(negedge hclk);
        end
        if (n == 20) check("xfer_timeout", {31'b0, hready}, 32'h1);
        rd   = hrdata;
        resp = hresp;
        next_cycle();
    endtask

    initial begin
        logic [31:0] rd;
        logic        resp;

        reset     = 1'b1;
        hsel      = 1'b0;
        haddr     = 32'h0;
        hwrite    = 1'b0;
        hsize     = 3'd2;
        hburst    = 3'd0;
        hmastlock = 1'b0;
        hprot     = 4'h0;
        htrans    = 2'b00;
        hwdata    = 32'h0;

        #2;
        check("rst_hready", {31'b0, hready}, 32'h1);
        check("rst_hresp",  {31'b0, hresp},  32'h0);
        check("rst_hrdata", hrdata, 32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Reset in the middle of a write data phase discards the write.
        xfer(1'b1, 32'h10, 3'd2, 32'h01234567, rd, resp);
        check("pre_wr_resp", {31'b0, resp}, 32'h0);
        addr_phase(1'b1, 32'h10, 3'd2);
        next_cycle();
        idle_bus();
        hwdata = 32'hDEADBEEF;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_hready", {31'b0, hready}, 32'h1);
        check("midrst_hresp",  {31'b0, hresp},  32'h0);
        check("midrst_hrdata", hrdata, 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        xfer(1'b0, 32'h10, 3'd2, 32'h0, rd, resp);
        check("midrst_rd", rd, 32'h01234567);

        // Byte and half lane merges.
        xfer(1'b1, 32'h20, 3'd2, 32'h11223344, rd, resp);
        xfer(1'b1, 32'h22, 3'd0, 32'h00AA0000, rd, resp);
        xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, resp);
        check("byte_merge", rd, 32'h11AA3344);
        xfer(1'b1, 32'h24, 3'd2, 32'h55667788, rd, resp);
        xfer(1'b1, 32'h26, 3'd1, 32'hCAFE0000, rd, resp);
        xfer(1'b0, 32'h24, 3'd2, 32'h0, rd, resp);
        check("half_merge", rd, 32'hCAFE7788);
        xfer(1'b1, 32'h29, 3'd0, 32'h0000EE00, rd, resp);
        xfer(1'b0, 32'h28, 3'd2, 32'h0, rd, resp);
        check("byte_lane1", rd[15:8], 32'hEE);

        // Exact wait-state timing on a read.
        xfer(1'b1, 32'h0, 3'd2, 32'hA5A5A5A5, rd, resp);
        addr_phase(1'b0, 32'h0, 3'd2);
        next_cycle();
        idle_bus();
        for (int i = 0; i < WS; i++) begin
            @(negedge hclk);
            check("wait_hready_low", {31'b0, hready}, 32'h0);
            next_cycle();
        end
        @(negedge hclk);
        check("wait_hready_high", {31'b0, hready}, 32'h1);
        check("wait_hresp", {31'b0, hresp}, 32'h0);
        check("wait_data", hrdata, 32'hA5A5A5A5);
        next_cycle();

        // Misaligned word read: two-cycle error, next NONSEQ accepted on the ERR2 edge.
        addr_phase(1'b0, 32'h6, 3'd2);
        next_cycle();
        idle_bus();
        @(negedge hclk);
        check("err1_hready", {31'b0, hready}, 32'h0);
        check("err1_hresp",  {31'b0, hresp},  32'h1);
        next_cycle();
        addr_phase(1'b0, 32'h0, 3'd2);
        @(negedge hclk);
        check("err2_hready", {31'b0, hready}, 32'h1);
        check("err2_hresp",  {31'b0, hresp},  32'h1);
        next_cycle();
        idle_bus();
        for (int i = 0; i < WS; i++) next_cycle();
        @(negedge hclk);
        check("after_err_hresp", {31'b0, hresp}, 32'h0);
        check("after_err_data", hrdata, 32'hA5A5A5A5);
        next_cycle();

        // Errored writes never touch memory.
        xfer(1'b1, 32'h21, 3'd1, 32'hFFFFFFFF, rd, resp);
        check("mis_half_resp", {31'b0, resp}, 32'h1);
        xfer(1'b0, 32'h20, 3'd2, 32'h0, rd, resp);
        check("mis_half_nochange", rd, 32'h11AA3344);
        xfer(1'b0, 32'h20, 3'd3, 32'h0, rd, resp);
        check("bad_size_resp", {31'b0, resp}, 32'h1);
        xfer(1'b1, 32'(DEPTH * 4), 3'd2, 32'hFFFFFFFF, rd, resp);
        check("oor_resp", {31'b0, resp}, 32'h1);
        xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, resp);
        check("oor_word0", rd, 32'hA5A5A5A5);
        check("ok_resp", {31'b0, resp}, 32'h0);
        xfer(1'b1, 32'(DEPTH * 4 - 4), 3'd2, 32'h0BADF00D, rd, resp);
        xfer(1'b0, 32'(DEPTH * 4 - 4), 3'd2, 32'h0, rd, resp);
        check("last_word", rd, 32'h0BADF00D);

        // Pipelined write then read of the same word.
        addr_phase(1'b1, 32'h40, 3'd2);
        next_cycle();
        hwdata = 32'h00000005;
        addr_phase(1'b0, 32'h40, 3'd2);
        for (int i = 0; i < WS; i++) next_cycle();
        @(negedge hclk);
        check("pipe_wr_done", {31'b0, hready}, 32'h1);
        next_cycle();
        idle_bus();
        for (int i = 0; i < WS; i++) next_cycle();
        @(negedge hclk);
        check("pipe_rd_hready", {31'b0, hready}, 32'h1);
        check("pipe_rd_data", hrdata, 32'h00000005);
        next_cycle();
        @(negedge hclk);
        check("idle_hrdata", hrdata, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_sram_slave.md
# vscale_hasti_sram_slave

AHB-Lite (HASTI) responder wrapping a single-port word-organised SRAM, the target end of the core's HASTI master port. Accepts single transfers from the core's HASTI bridge, performs byte/half/word reads and writes with a compile-time-selectable wait-state counter, and returns the two-cycle HASTI error response on out-of-range or misaligned accesses. Used as instruction/data memory in simulation testbenches and small SoC builds.

## Interface
- DEPTH, 1024: memory size in 32-bit words; valid word index is haddr[31:2] < DEPTH.
- WAIT_STATES, 1: data-phase wait cycles inserted per OK transfer (only with wait feature compiled in).

- hclk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  32  byte address (address phase).
- hwrite  in  1  1 = write.
- hsize  in  3  0 byte, 1 half, 2 word; others -> error.
- hburst  in  3  ignored (single only).
- hmastlock  in  1  ignored.
- hprot  in  4  ignored.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwdata  in  32  write data (data phase), little-endian lanes.
- hrdata  out  32  read data, valid when hready=1 in read data phase.
- hready  out  1  transfer done / slave ready for next address phase.
- hresp  out  1  0 OKAY, 1 ERROR.

## Operation
- Address phase accepted on a rising edge where hready=1, hsel=1, htrans[1]=1; captures index, hwrite, hsize, byte offset haddr[1:0]. Otherwise no transfer.
- Error check at acceptance: index >= DEPTH, hsize>2, half with haddr[0]=1, word with haddr[1:0]!=0.
- FSM: IDLE -> DATA (accepted, OK) or ERR1 (accepted, error). DATA -> stays while wait count < WAIT_STATES; completes when count==WAIT_STATES, then goes to DATA/ERR1/IDLE per the address phase sampled that edge. ERR1 -> ERR2 unconditionally. ERR2 completes, next state per address sampled that edge.
- Outputs: IDLE hready=1 hresp=0; DATA hready=(count==WAIT_STATES) hresp=0; ERR1 hready=0 hresp=1; ERR2 hready=1 hresp=1.
- Write commit on the completing edge of DATA: byte lanes enabled per hsize/offset (byte: lane offset; half: lanes 2*haddr[1]..+1; word: all). Unselected lanes unchanged. Errored writes never modify memory.
- Read: hrdata = mem[captured index] (full word, all lanes) in DATA of a read; 0 in all other states.
- Wait counter: width clog2(WAIT_STATES+1), cleared on entry to DATA, increments while hready=0; never wraps.
- BUSY/IDLE htrans during wait cycles ignored (not sampled while hready=0).
- Memory contents not reset.

## Timing
- Reset (async assert): state IDLE, hready=1, hresp=0, hrdata=0, counter 0; in-flight write discarded.
- Address phase in cycle N; data phase N+1. Zero-wait: hready=1 in N+1, write commits at end of N+1.
- W wait states: hready=0 for cycles N+1..N+W, 1 at N+W+1.
- Error: hready=0/hresp=1 at N+1, hready=1/hresp=1 at N+2.
- Back-to-back write A then read A: read data phase sees the new value (write committed at the edge that starts the read data phase).
- Pipelined transfers sustain one per cycle at zero wait.

## Configuration
- VSCALE_HASTI_SLAVE_WAIT_EN defined: wait-state counter and WAIT_STATES parameter active as above.
- Undefined: counter not built; every OK transfer completes in its first data-phase cycle (effective WAIT_STATES=0); error response unchanged.

## Test plan
- Reset asserted mid-wait on a write of 0xDEADBEEF to 0x10 -> hready=1, hresp=0, hrdata=0 immediately; later read of 0x10 does not return 0xDEADBEEF.
- Word write 0x11223344 @0x20, then byte write 0xAA (hwdata 0x00AA0000) @0x22, read @0x20 -> 0x11AA3344.
- WAIT_STATES=2, read @0x0 -> hready low exactly 2 cycles after address phase, high on 3rd with correct data, hresp=0.
- Word read @0x6 (misaligned) -> hready 0/hresp 1, then hready 1/hresp 1; memory unchanged; next NONSEQ accepted on ERR2 edge.
- Write @ byte address DEPTH*4 -> two-cycle error; word 0 unaltered.
- Zero-wait pipelined write 0x5 @0x40 immediately followed by read @0x40 -> read returns 0x00000005 one cycle after write completes.
